// File: rtl/reorder_buffer_pkg.sv
// Shared constants, entry layout and index helper for the reorder buffer.
package reorder_buffer_pkg;

  localparam int ROB_SIZE  = 16;
  localparam int ROB_IDX_W = 4;

  typedef logic [ROB_IDX_W-1:0] rob_idx_t;
  typedef logic [ROB_IDX_W:0]   rob_cnt_t;

  // Instruction kinds as carried by the decoder.
  localparam logic [1:0] ROB_REG  = 2'd0;
  localparam logic [1:0] ROB_BR   = 2'd1;
  localparam logic [1:0] ROB_ST   = 2'd2;
  localparam logic [1:0] ROB_JALR = 2'd3;

  localparam logic        TRUE   = 1'b1;
  localparam logic        FALSE  = 1'b0;
  localparam logic [31:0] ZERO32 = 32'd0;
  localparam rob_idx_t    ZERO4  = '0;

  localparam rob_cnt_t ROB_FULL_COUNT = rob_cnt_t'(ROB_SIZE);

  // Payload of one queue slot; busy/ready flags are kept as separate vectors.
  typedef struct packed {
    logic [1:0]  kind;
    logic [4:0]  rd;
    logic [31:0] val;
    logic        pred;
    logic [31:0] alt;
  } rob_entry_t;

  // Circular-queue successor; the index width makes 15 wrap to 0.
  function automatic rob_idx_t robNext(input rob_idx_t idx);
    return idx + rob_idx_t'(1);
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order allocation, out-of-order result capture from the
// ALU and LSB buses, in-order retirement with branch/JALR redirect at commit.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,

  input  logic        issue_flag_in,
  input  logic [1:0]  issue_kind_in,
  input  logic [4:0]  issue_rd_in,
  input  logic [31:0] issue_val_in,
  input  logic        issue_ready_in,
  input  logic        issue_pred_in,
  input  logic [31:0] issue_alt_in,
  output logic [3:0]  rob_idx_out,
  output logic        full_out,

  input  logic        alu_flag_in,
  input  logic [31:0] alu_val_in,
  input  logic [3:0]  alu_to_ROB_in,

  input  logic        LSB_flag_in,
  input  logic [31:0] LSB_val_in,
  input  logic [3:0]  LSB_to_ROB_in,

  input  logic [3:0]  q1_idx_in,
  input  logic [3:0]  q2_idx_in,
  output logic        q1_ready_out,
  output logic        q2_ready_out,
  output logic [31:0] q1_val_out,
  output logic [31:0] q2_val_out,

  output logic        commit_flag_out,
  output logic [4:0]  commit_rd_out,
  output logic [31:0] commit_val_out,
  output logic [3:0]  commit_rob_out,
  output logic        store_commit_out,
  output logic        jump_wrong_out,
  output logic [31:0] jump_pc_out
);

  rob_entry_t          r_entry [ROB_SIZE];
  logic [ROB_SIZE-1:0] r_busy;
  logic [ROB_SIZE-1:0] r_ready;
  rob_idx_t            r_head;
  rob_idx_t            r_tail;
  rob_cnt_t            r_count;

  rob_entry_t w_head;
  logic       w_issue;
  logic       w_commit;
  logic       w_redirect;

  assign rob_idx_out = r_tail;
  assign full_out    = (r_count == ROB_FULL_COUNT);
  assign w_head      = r_entry[r_head];

  // Issue is refused when full and during the redirect pulse, since the
  // decoder is still fetching down the wrong path in that cycle.
  assign w_issue    = issue_flag_in & ~full_out & ~jump_wrong_out;
  assign w_commit   = r_busy[r_head] & r_ready[r_head];
  assign w_redirect = w_commit &
                      ((w_head.kind == ROB_JALR) |
                       ((w_head.kind == ROB_BR) & (w_head.val[0] != w_head.pred)));

  // Operand lookup with same-cycle forwarding: ALU beats LSB beats stored state.
  always_comb begin
    q1_ready_out = r_ready[q1_idx_in];
    q1_val_out   = r_entry[q1_idx_in].val;
    q2_ready_out = r_ready[q2_idx_in];
    q2_val_out   = r_entry[q2_idx_in].val;
    if (LSB_flag_in && (LSB_to_ROB_in == q1_idx_in)) begin
      q1_ready_out = TRUE;
      q1_val_out   = LSB_val_in;
    end
    if (alu_flag_in && (alu_to_ROB_in == q1_idx_in)) begin
      q1_ready_out = TRUE;
      q1_val_out   = alu_val_in;
    end
    if (LSB_flag_in && (LSB_to_ROB_in == q2_idx_in)) begin
      q2_ready_out = TRUE;
      q2_val_out   = LSB_val_in;
    end
    if (alu_flag_in && (alu_to_ROB_in == q2_idx_in)) begin
      q2_ready_out = TRUE;
      q2_val_out   = alu_val_in;
    end
  end

  // Queue state and registered commit outputs; later assignments in this
  // block take precedence, so a redirect overrides issue, capture and commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy           <= '0;
      r_ready          <= '0;
      r_head           <= ZERO4;
      r_tail           <= ZERO4;
      r_count          <= '0;
      commit_flag_out  <= FALSE;
      commit_rd_out    <= '0;
      commit_val_out   <= ZERO32;
      commit_rob_out   <= ZERO4;
      store_commit_out <= FALSE;
      jump_wrong_out   <= FALSE;
      jump_pc_out      <= ZERO32;
      for (int i = 0; i < ROB_SIZE; i++) begin
        r_entry[i] <= '0;
      end
    end else if (!rdy) begin
      commit_flag_out  <= FALSE;
      store_commit_out <= FALSE;
      jump_wrong_out   <= FALSE;
    end else begin
      commit_flag_out  <= FALSE;
      store_commit_out <= FALSE;
      jump_wrong_out   <= FALSE;

      for (int i = 0; i < ROB_SIZE; i++) begin
        if (r_busy[i] && !r_ready[i]) begin
          if (alu_flag_in && (alu_to_ROB_in == rob_idx_t'(i))) begin
            r_ready[i]     <= TRUE;
            r_entry[i].val <= alu_val_in;
          end else if (LSB_flag_in && (LSB_to_ROB_in == rob_idx_t'(i))) begin
            r_ready[i]     <= TRUE;
            r_entry[i].val <= LSB_val_in;
          end
        end
      end

      if (w_issue) begin
        r_entry[r_tail].kind <= issue_kind_in;
        r_entry[r_tail].rd   <= issue_rd_in;
        r_entry[r_tail].val  <= issue_val_in;
        r_entry[r_tail].pred <= issue_pred_in;
        r_entry[r_tail].alt  <= issue_alt_in;
        r_busy[r_tail]       <= TRUE;
        r_ready[r_tail]      <= issue_ready_in;
        r_tail               <= robNext(r_tail);
      end

      if (w_commit) begin
        r_busy[r_head] <= FALSE;
        r_head         <= robNext(r_head);
        commit_rob_out <= r_head;
        case (w_head.kind)
          ROB_REG: begin
            commit_flag_out <= TRUE;
            commit_rd_out   <= w_head.rd;
            commit_val_out  <= w_head.val;
          end
          ROB_ST: begin
            store_commit_out <= TRUE;
          end
          ROB_JALR: begin
            commit_flag_out <= TRUE;
            commit_rd_out   <= w_head.rd;
            commit_val_out  <= w_head.alt;
          end
          default: begin
          end
        endcase
      end

      case ({w_issue, w_commit})
        2'b10:   r_count <= r_count + rob_cnt_t'(1);
        2'b01:   r_count <= r_count - rob_cnt_t'(1);
        default: r_count <= r_count;
      endcase

      if (w_redirect) begin
        r_busy         <= '0;
        r_head         <= ZERO4;
        r_tail         <= ZERO4;
        r_count        <= '0;
        jump_wrong_out <= TRUE;
        jump_pc_out    <= (w_head.kind == ROB_JALR) ? w_head.val : w_head.alt;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed stimulus pushes expected
// retirement events into a scoreboard that a negedge monitor drains.
module tb_reorder_buffer;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        issue_flag_in;
  logic [1:0]  issue_kind_in;
  logic [4:0]  issue_rd_in;
  logic [31:0] issue_val_in;
  logic        issue_ready_in;
  logic        issue_pred_in;
  logic [31:0] issue_alt_in;
  logic [3:0]  rob_idx_out;
  logic        full_out;
  logic        alu_flag_in;
  logic [31:0] alu_val_in;
  logic [3:0]  alu_to_ROB_in;
  logic        LSB_flag_in;
  logic [31:0] LSB_val_in;
  logic [3:0]  LSB_to_ROB_in;
  logic [3:0]  q1_idx_in;
  logic [3:0]  q2_idx_in;
  logic        q1_ready_out;
  logic        q2_ready_out;
  logic [31:0] q1_val_out;
  logic [31:0] q2_val_out;
  logic        commit_flag_out;
  logic [4:0]  commit_rd_out;
  logic [31:0] commit_val_out;
  logic [3:0]  commit_rob_out;
  logic        store_commit_out;
  logic        jump_wrong_out;
  logic [31:0] jump_pc_out;

  typedef struct {
    logic        flag;
    logic        store;
    logic        jump;
    logic [4:0]  rd;
    logic [31:0] val;
    logic [3:0]  rob;
    logic [31:0] pc;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t expItem;
  int   cyc = 0;
  int   assertCount = 0;
  int   failCount = 0;

  reorder_buffer dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_flag_in(issue_flag_in), .issue_kind_in(issue_kind_in),
    .issue_rd_in(issue_rd_in), .issue_val_in(issue_val_in),
    .issue_ready_in(issue_ready_in), .issue_pred_in(issue_pred_in),
    .issue_alt_in(issue_alt_in), .rob_idx_out(rob_idx_out), .full_out(full_out),
    .alu_flag_in(alu_flag_in), .alu_val_in(alu_val_in), .alu_to_ROB_in(alu_to_ROB_in),
    .LSB_flag_in(LSB_flag_in), .LSB_val_in(LSB_val_in), .LSB_to_ROB_in(LSB_to_ROB_in),
    .q1_idx_in(q1_idx_in), .q2_idx_in(q2_idx_in),
    .q1_ready_out(q1_ready_out), .q2_ready_out(q2_ready_out),
    .q1_val_out(q1_val_out), .q2_val_out(q2_val_out),
    .commit_flag_out(commit_flag_out), .commit_rd_out(commit_rd_out),
    .commit_val_out(commit_val_out), .commit_rob_out(commit_rob_out),
    .store_commit_out(store_commit_out), .jump_wrong_out(jump_wrong_out),
    .jump_pc_out(jump_pc_out)
  );

  // 10-time-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to check retirement latency
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic clearInputs();
    issue_flag_in = 1'b0;
    alu_flag_in   = 1'b0;
    LSB_flag_in   = 1'b0;
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
    clearInputs();
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    clearInputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic driveIssue(input logic [1:0] kind, input logic [4:0] rd,
                            input logic [31:0] val, input logic readyIn,
                            input logic pred, input logic [31:0] alt);
    issue_flag_in  = 1'b1;
    issue_kind_in  = kind;
    issue_rd_in    = rd;
    issue_val_in   = val;
    issue_ready_in = readyIn;
    issue_pred_in  = pred;
    issue_alt_in   = alt;
  endtask

  task automatic driveAlu(input logic [3:0] idx, input logic [31:0] val);
    alu_flag_in   = 1'b1;
    alu_to_ROB_in = idx;
    alu_val_in    = val;
  endtask

  task automatic driveLsb(input logic [3:0] idx, input logic [31:0] val);
    LSB_flag_in   = 1'b1;
    LSB_to_ROB_in = idx;
    LSB_val_in    = val;
  endtask

  task automatic pushExpect(input logic flag, input logic store, input logic jump,
                            input logic [4:0] rd, input logic [31:0] val,
                            input logic [3:0] rob, input logic [31:0] pc,
                            input int offset);
    exp_t e;
    e.flag  = flag;
    e.store = store;
    e.jump  = jump;
    e.rd    = rd;
    e.val   = val;
    e.rob   = rob;
    e.pc    = pc;
    e.due   = cyc + offset;
    sb.push_back(e);
  endtask

  // Monitor: every retirement pulse must match the oldest expected event
  always @(negedge clk) begin
    if (!rst && (commit_flag_out || store_commit_out || jump_wrong_out)) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected pulse",
                    {29'd0, commit_flag_out, store_commit_out, jump_wrong_out}, 32'd0);
      end else begin
        expItem = sb.pop_front();
        checkOutput("pulse cycle", cyc, expItem.due);
        checkOutput("commit_flag", commit_flag_out, expItem.flag);
        checkOutput("store_commit", store_commit_out, expItem.store);
        checkOutput("jump_wrong", jump_wrong_out, expItem.jump);
        checkOutput("commit_rob", commit_rob_out, expItem.rob);
        if (expItem.flag) begin
          checkOutput("commit_rd", commit_rd_out, expItem.rd);
          checkOutput("commit_val", commit_val_out, expItem.val);
        end
        if (expItem.jump) begin
          checkOutput("jump_pc", jump_pc_out, expItem.pc);
        end
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  // Directed stimulus
  initial begin
    rdy = 1'b1;
    rst = 1'b1;
    issue_kind_in = '0; issue_rd_in = '0; issue_val_in = '0;
    issue_ready_in = 1'b0; issue_pred_in = 1'b0; issue_alt_in = '0;
    alu_val_in = '0; alu_to_ROB_in = '0; LSB_val_in = '0; LSB_to_ROB_in = '0;
    q1_idx_in = '0; q2_idx_in = '0;
    clearInputs();
    doReset();

    @(negedge clk);
    checkOutput("reset rob_idx", rob_idx_out, 32'd0);
    checkOutput("reset full", full_out, 32'd0);
    checkOutput("reset commit_flag", commit_flag_out, 32'd0);
    checkOutput("reset store_commit", store_commit_out, 32'd0);
    checkOutput("reset jump_wrong", jump_wrong_out, 32'd0);
    checkOutput("reset jump_pc", jump_pc_out, 32'd0);
    checkOutput("reset commit_val", commit_val_out, 32'd0);
    waitCycles(1);

    $display("[TB] basic register write");
    driveIssue(2'd0, 5'd5, 32'd0, 1'b0, 1'b0, 32'd0);
    applyStimulus();
    driveAlu(4'd0, 32'h1234);
    pushExpect(1, 0, 0, 5'd5, 32'h1234, 4'd0, 0, 2);
    applyStimulus();
    waitCycles(4);

    $display("[TB] in-order retirement");
    driveIssue(2'd0, 5'd6, 32'd0, 1'b0, 1'b0, 32'd0);
    applyStimulus();
    driveIssue(2'd0, 5'd7, 32'd0, 1'b0, 1'b0, 32'd0);
    applyStimulus();
    driveAlu(4'd2, 32'hBBBB);
    applyStimulus();
    q1_idx_in = 4'd2;
    q2_idx_in = 4'd1;
    @(negedge clk);
    checkOutput("lookup B ready", q1_ready_out, 32'd1);
    checkOutput("lookup B val", q1_val_out, 32'hBBBB);
    checkOutput("lookup A not ready", q2_ready_out, 32'd0);
    waitCycles(3);
    driveAlu(4'd1, 32'hAAAA);
    pushExpect(1, 0, 0, 5'd6, 32'hAAAA, 4'd1, 0, 2);
    pushExpect(1, 0, 0, 5'd7, 32'hBBBB, 4'd2, 0, 3);
    applyStimulus();
    waitCycles(4);
    driveIssue(2'd0, 5'd9, 32'h55, 1'b1, 1'b0, 32'd0);
    pushExpect(1, 0, 0, 5'd9, 32'h55, 4'd3, 0, 2);
    applyStimulus();
    waitCycles(4);

    $display("[TB] full and wrap");
    doReset();
    for (int i = 0; i < 16; i++) begin
      driveIssue(2'd0, 5'(i + 1), 32'd0, 1'b0, 1'b0, 32'd0);
      applyStimulus();
    end
    @(negedge clk);
    checkOutput("full after 16", full_out, 32'd1);
    checkOutput("tail wrapped", rob_idx_out, 32'd0);
    driveIssue(2'd0, 5'd31, 32'hDEAD, 1'b1, 1'b0, 32'd0);
    q1_idx_in = 4'd0;
    applyStimulus();
    @(negedge clk);
    checkOutput("17th issue full", full_out, 32'd1);
    checkOutput("17th issue ignored", q1_ready_out, 32'd0);
    checkOutput("17th issue tail", rob_idx_out, 32'd0);
    driveAlu(4'd0, 32'h100);
    pushExpect(1, 0, 0, 5'd1, 32'h100, 4'd0, 0, 2);
    applyStimulus();
    driveIssue(2'd0, 5'd21, 32'h99, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    checkOutput("full during commit", full_out, 32'd1);
    applyStimulus();
    @(negedge clk);
    checkOutput("slot freed", full_out, 32'd0);
    checkOutput("tail after free", rob_idx_out, 32'd0);
    driveIssue(2'd0, 5'd20, 32'h77, 1'b0, 1'b0, 32'd0);
    applyStimulus();
    @(negedge clk);
    checkOutput("tail advanced", rob_idx_out, 32'd1);
    checkOutput("full again", full_out, 32'd1);
    waitCycles(2);

    $display("[TB] branch mispredict");
    doReset();
    @(negedge clk);
    checkOutput("mid reset full", full_out, 32'd0);
    checkOutput("mid reset tail", rob_idx_out, 32'd0);
    driveIssue(2'd1, 5'd0, 32'd0, 1'b0, 1'b0, 32'h1000);
    applyStimulus();
    driveIssue(2'd0, 5'd3, 32'h33, 1'b1, 1'b0, 32'd0);
    applyStimulus();
    driveAlu(4'd0, 32'd1);
    pushExpect(0, 0, 1, 5'd0, 32'd0, 4'd0, 32'h1000, 2);
    applyStimulus();
    driveIssue(2'd0, 5'd4, 32'h44, 1'b1, 1'b0, 32'd0);
    applyStimulus();
    driveIssue(2'd0, 5'd5, 32'h45, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    checkOutput("flush tail", rob_idx_out, 32'd0);
    applyStimulus();
    @(negedge clk);
    checkOutput("issue during redirect dropped", rob_idx_out, 32'd0);
    checkOutput("flush full", full_out, 32'd0);
    waitCycles(3);
    driveIssue(2'd1, 5'd0, 32'd0, 1'b0, 1'b0, 32'h1000);
    applyStimulus();
    driveAlu(4'd0, 32'd0);
    applyStimulus();
    waitCycles(3);
    @(negedge clk);
    checkOutput("correct prediction tail", rob_idx_out, 32'd1);

    $display("[TB] frozen and JALR");
    doReset();
    rdy = 1'b0;
    driveIssue(2'd0, 5'd8, 32'h88, 1'b1, 1'b0, 32'd0);
    applyStimulus();
    waitCycles(2);
    @(negedge clk);
    checkOutput("frozen tail", rob_idx_out, 32'd0);
    rdy = 1'b1;
    waitCycles(1);
    driveIssue(2'd3, 5'd1, 32'd0, 1'b0, 1'b0, 32'h24);
    applyStimulus();
    driveAlu(4'd0, 32'h400);
    pushExpect(1, 0, 1, 5'd1, 32'h24, 4'd0, 32'h400, 2);
    applyStimulus();
    waitCycles(4);

    $display("[TB] forwarding and capture");
    doReset();
    for (int i = 0; i < 4; i++) begin
      driveIssue(2'd0, 5'(10 + i), 32'd0, 1'b0, 1'b0, 32'd0);
      applyStimulus();
    end
    q1_idx_in = 4'd3;
    q2_idx_in = 4'd2;
    driveAlu(4'd3, 32'd7);
    driveLsb(4'd2, 32'd9);
    @(negedge clk);
    checkOutput("fwd alu ready", q1_ready_out, 32'd1);
    checkOutput("fwd alu val", q1_val_out, 32'd7);
    checkOutput("fwd lsb ready", q2_ready_out, 32'd1);
    checkOutput("fwd lsb val", q2_val_out, 32'd9);
    applyStimulus();
    @(negedge clk);
    checkOutput("stored alu val", q1_val_out, 32'd7);
    checkOutput("stored lsb ready", q2_ready_out, 32'd1);
    checkOutput("stored lsb val", q2_val_out, 32'd9);
    q1_idx_in = 4'd0;
    @(negedge clk);
    checkOutput("head not ready", q1_ready_out, 32'd0);
    waitCycles(2);

    $display("[TB] store commit");
    doReset();
    driveIssue(2'd2, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    applyStimulus();
    driveLsb(4'd0, 32'hABC);
    pushExpect(0, 1, 0, 5'd0, 32'd0, 4'd0, 0, 2);
    applyStimulus();
    waitCycles(4);

    @(negedge clk);
    checkOutput("scoreboard drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Reorder buffer downstream of the reservation station and load/store buffer. It allocates one 16-entry circular-queue slot per decoded instruction and captures results from the ALU and LSB broadcast buses. Entries retire in program order: register writes go to the register file, stores are released to the LSB, and branch/JALR redirects are resolved at commit. It also supplies operand status to the decoder for renaming.

## Interface
- ROB_SIZE, 16, number of entries; index width 4 (`ROB_INDEX_RANGE` = 3:0)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; low freezes all state
- issue_flag_in  in  1  decoder issues one instruction this cycle
- issue_kind_in  in  2  0 = reg-write (ALU/load/JAL), 1 = branch, 2 = store, 3 = JALR
- issue_rd_in  in  5  destination register; ignored for kinds 1 and 2
- issue_val_in  in  32  value known at issue (JAL link); entry is ready at once if issue_ready_in
- issue_ready_in  in  1  entry needs no execution result
- issue_pred_in  in  1  predicted taken (branch only)
- issue_alt_in  in  32  branch: the not-predicted PC; JALR: link value pc+4
- rob_idx_out  out  4  tail index to be allocated (combinational)
- full_out  out  1  count == ROB_SIZE (combinational)
- alu_flag_in / alu_val_in / alu_to_ROB_in  in  1/32/4  ALU result bus
- LSB_flag_in / LSB_val_in / LSB_to_ROB_in  in  1/32/4  LSB result bus (also marks stores ready)
- q1_idx_in, q2_idx_in  in  4  decoder lookups
- q1_ready_out, q2_ready_out  out  1  entry value available (combinational)
- q1_val_out, q2_val_out  out  32  entry value
- commit_flag_out  out  1  register-write pulse
- commit_rd_out  out  5  destination register
- commit_val_out  out  32  value to write
- commit_rob_out  out  4  index of the retired entry
- store_commit_out  out  1  pulse; LSB performs the store tagged commit_rob_out
- jump_wrong_out  out  1  mispredict/redirect pulse to all units
- jump_pc_out  out  32  redirect target

## Operation
- Per-entry state: busy, ready, kind, rd, val, pred, alt. Queue state: head, tail, count (5 bits).
- Issue: if issue_flag_in, !full_out, and !jump_wrong_out, write entry[tail]. busy=1, ready=issue_ready_in. tail wraps 15→0.
- Capture: for each busy, not-ready entry whose index matches a valid bus, set ready=1 and val=bus value. The ALU and LSB buses may both fire in one cycle on different indices; both are applied. A bus never targets the entry being issued that cycle.
- Lookup: qN_ready_out/qN_val_out come from entry[qN_idx_in]. Same-cycle forwarding applies: an ALU match wins over an LSB match, which wins over stored state.
- Commit: one entry per cycle, when entry[head] is busy and ready. Then busy is cleared and head increments (wraps).
  - kind 0: commit_flag_out=1, rd, val.
  - kind 2: store_commit_out=1.
  - kind 1: if val[0] != pred, mispredict; jump_pc_out=alt.
  - kind 3: commit_flag_out=1 with val=alt (link), rd; always redirect with jump_pc_out = val.
- Mispredict/redirect at edge E: all busy cleared, head=tail=count=0, jump_wrong_out=1 for the cycle after E. Any issue in the same cycle is discarded. For JALR, the link write is still emitted in the same cycle.
- Count: +1 on issue, −1 on commit; unchanged when both occur.
- While rdy is low, no state changes and all pulse outputs are 0.

## Timing
- Reset: all busy=0; head=tail=count=0; every registered output 0; rob_idx_out=0; full_out=0.
- Issue → entry visible to lookup the next cycle.
- A result captured at edge N can commit at edge N+1 at earliest, and the pulse is visible the cycle after.
- Issue to an empty ROB with issue_ready_in=1 → commit pulse 2 cycles after issue.
- Pulse outputs are registered, high exactly one cycle, and default to 0 in every cycle without commit.
- Full: issue_flag_in while full_out is ignored. If a commit happens the same cycle, the slot frees for the next cycle only.
- Reset mid-operation overrides issue, capture, and commit in that cycle.

## Structure
- define.v holds: ROB_SIZE, `ROB_INDEX_RANGE`, the kind codes (ROB_REG, ROB_BR, ROB_ST, ROB_JALR), TRUE/FALSE, ZERO32, ZERO4.
- The block is a single module with no sub-module; queue pointers, capture, and lookup live inline.

## Test plan
- Issue kind 0, rd=5 (not ready); ALU bus idx 0, value 0x1234 → commit_flag_out with rd=5, val=0x1234, commit_rob_out=0.
- Issue A (idx0) and B (idx1); result for B arrives first → no commit until A's result arrives; then A and B commit on consecutive cycles.
- Issue 16 entries → full_out=1 and a 17th issue is ignored; commit one and issue → tail wraps to 0.
- Branch pred=0, alt=0x1000, ALU val=1 → jump_wrong_out=1 with jump_pc_out=0x1000, then count=0 and rob_idx_out=0. The same branch with val=0 → no redirect.
- JALR rd=1, alt=0x24, ALU val=0x400 → commit of rd=1 val=0x24, plus jump_wrong_out with jump_pc_out=0x400.
- Lookup of idx 3 while the ALU bus carries idx 3 value 7 that cycle → q1_ready_out=1, q1_val_out=7. Store entry made ready by the LSB bus → store_commit_out pulse, no register write.
